sprite_mover: RTL
=================

Name: sprite_mover

Overview:
- Parametrised successor of the game's bird datapath. Holds one sprite's position and applies movement commands: diagonal move, fall and escape, all clamped to the screen.
- Rasterises a solid SPRITE_W x SPRITE_H box (draw or clear) as one pixel per cycle toward the VGA adapter.
- Sits between a per-sprite control FSM (command master) and the VGA plot arbiter.

Parameters:
- SCREEN_W, 160, screen width in pixels.
- SCREEN_H, 120, screen height in pixels.
- SPRITE_W, 4, sprite width in pixels (1..16).
- SPRITE_H, 4, sprite height in pixels (1..16).
- COLOUR_W, 3, colour width.
- STEP, 1, pixels per move/fall/escape command.
- START_X, 80, position loaded by reset and CMD_HOME.
- START_Y, 60, position loaded by reset and CMD_HOME.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd  in  3  opcode: HOME=0, MOVE=1, FALL=2, ESCAPE=3, DRAW=4, CLEAR=5; 6 and 7 are no-ops.
- dir  in  2  MOVE direction: bit0 1=right/0=left, bit1 1=down/0=up.
- draw_colour  in  COLOUR_W  colour latched when DRAW is accepted.
- x_out  out  X_W  pixel x, where X_W = $clog2(SCREEN_W).
- y_out  out  Y_W  pixel y, where Y_W = $clog2(SCREEN_H).
- colour  out  COLOUR_W  pixel colour.
- plot  out  1  x_out/y_out/colour valid this cycle.
- done  out  1  one-cycle pulse at the end of a sweep.
- flying  out  1  FALL/ESCAPE still travelling.
- pos_x  out  X_W  current top-left x.
- pos_y  out  Y_W  current top-left y.

Behaviour:
- Reset (asynchronous) sets:
  - pos to START_X/START_Y;
  - x_out, y_out, colour, plot, done and flying to 0;
  - state to IDLE, so cmd_ready=1.
- Clamp limits: XMAX = SCREEN_W-SPRITE_W, YMAX = SCREEN_H-SPRITE_H. pos never leaves [0,XMAX] x [0,YMAX].
- Handshake: a command is accepted when cmd_valid && cmd_ready. cmd_ready = (state==IDLE). Commands offered while busy are held off, never dropped.
- States are IDLE and SWEEP.
- HOME, MOVE, FALL and ESCAPE execute in the accept cycle. pos updates on that edge and the block stays in IDLE.
- HOME: pos <= START; flying <= 0.
- MOVE: x moves ±STEP and y moves ±STEP, each saturating at 0 or its MAX. Arithmetic is done at X_W+1 / Y_W+1 bits, so there is no wrap-around.
- FALL: if pos_y < YMAX, pos_y <= min(pos_y+STEP, YMAX) and flying <= 1; otherwise flying <= 0 and pos is unchanged.
- ESCAPE: if pos_y > 0, pos_y <= max(pos_y-STEP, 0) and flying <= 1; otherwise flying <= 0.
- DRAW/CLEAR accept:
  - latch colour (DRAW: draw_colour; CLEAR: 0);
  - snapshot pos into the sweep base;
  - clear the column/row counters;
  - go to SWEEP.
- SWEEP, one pixel per cycle:
  - plot=1, x_out=base_x+col, y_out=base_y+row;
  - pixel order is row-major, col fastest;
  - exactly SPRITE_W*SPRITE_H consecutive plot cycles; the first plot is registered, appearing the cycle after accept.
- Sweep end: the final pixel (col=SPRITE_W-1, row=SPRITE_H-1) is presented together with done=1 in the same cycle, and state returns to IDLE on that edge. A new command is therefore accepted one cycle after done.
- Outside SWEEP, plot=0 and done=0. x_out, y_out and colour hold their last values.
- Latency example (defaults): DRAW accepted at cycle 0 → plots on cycles 1..16 → done on cycle 16 → cmd_ready=1 on cycle 17.
- Reset mid-sweep aborts immediately: plot=0, done is never pulsed, pos returns to START.
- Sweep pixels always stay on screen because pos is clamped.

Optional Feature:
- Macro: SPRITE_MOVER_HIT_EN.
- When defined, adds ports:
  - aim_x  in  X_W;
  - aim_y  in  Y_W;
  - fire  in  1;
  - hit  out  1.
- Registered hit behaviour: hit pulses 1 the cycle after fire=1 while aim lies inside [pos_x, pos_x+SPRITE_W-1] x [pos_y, pos_y+SPRITE_H-1]. The comparison uses pos before any same-cycle MOVE update.
- fire is ignored while flying=1.
- When not defined, none of these ports or comparison logic exist.

Decomposition:
- Shared package sprite_pkg holds:
  - opcode localparams CMD_HOME..CMD_CLEAR;
  - direction bit indices DIR_RIGHT_BIT and DIR_DOWN_BIT;
  - the state encoding.
- One natural sub-module: sprite_raster_counter, parametrised by SPRITE_W/SPRITE_H. It provides the col/row counters, the start input and the last-pixel (done) flag.

Test Plan:
- Reset, then DRAW with colour 3'b111 at defaults: 16 plots, (80,60),(81,60)…(83,63); done coincides with (83,63); cmd_ready rises next cycle.
- Pos (0,0), MOVE dir=2'b00 (up-left) ×3: pos stays (0,0). Pos (156,116), MOVE dir=2'b11: pos stays (156,116).
- ESCAPE from y=2 with STEP=1: y becomes 1 then 0 with flying=1; third ESCAPE leaves y=0 and clears flying. FALL from y=115 reaches 116 (YMAX), then flying=0.
- cmd_valid held during sweep with MOVE: not accepted until the cycle after done. Pos snapshot unaffected; all 16 sweep pixels use the old base.
- Reset asserted at the 5th plot cycle: plot drops asynchronously, no done pulse, pos=(80,60), cmd_ready=1.
- Parameters SPRITE_W=8, SPRITE_H=2, STEP=3; CLEAR at (10,20): 16 plots with colour 0, last pixel (17,21). With SPRITE_MOVER_HIT_EN: fire at aim (17,21) → hit=1 next cycle; aim (18,21) → hit=0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared opcodes, direction bit positions and FSM encoding for the sprite mover.
package sprite_pkg;

  localparam logic [2:0] CMD_HOME   = 3'd0;
  localparam logic [2:0] CMD_MOVE   = 3'd1;
  localparam logic [2:0] CMD_FALL   = 3'd2;
  localparam logic [2:0] CMD_ESCAPE = 3'd3;
  localparam logic [2:0] CMD_DRAW   = 3'd4;
  localparam logic [2:0] CMD_CLEAR  = 3'd5;

  localparam int DIR_RIGHT_BIT = 0;
  localparam int DIR_DOWN_BIT  = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

endpackage

// File: rtl/sprite_raster_counter.sv
// Column/row scan counter for a SPRITE_W x SPRITE_H box, column fastest.
module sprite_raster_counter #(
  parameter int SPRITE_W = 4,
  parameter int SPRITE_H = 4,
  localparam int CW = $clog2(SPRITE_W + 1),
  localparam int RW = $clog2(SPRITE_H + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          advance,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  localparam logic [CW-1:0] COL_LAST = CW'(SPRITE_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(SPRITE_H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (start) begin
      col_d = '0;
      row_d = '0;
    end else if (advance) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state is written only with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/sprite_mover.sv
// One sprite's clamped position plus a one-pixel-per-cycle box rasteriser.
// Optional aim/fire hit detection is compiled in with SPRITE_MOVER_HIT_EN.
module sprite_mover
  import sprite_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int SPRITE_W = 4,
  parameter int SPRITE_H = 4,
  parameter int COLOUR_W = 3,
  parameter int STEP     = 1,
  parameter int START_X  = 80,
  parameter int START_Y  = 60,
  localparam int X_W = $clog2(SCREEN_W),
  localparam int Y_W = $clog2(SCREEN_H)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd,
  input  logic [1:0]          dir,
  input  logic [COLOUR_W-1:0] draw_colour,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                done,
  output logic                flying,
  output logic [X_W-1:0]      pos_x,
  output logic [Y_W-1:0]      pos_y
`ifdef SPRITE_MOVER_HIT_EN
  ,
  input  logic [X_W-1:0]      aim_x,
  input  logic [Y_W-1:0]      aim_y,
  input  logic                fire,
  output logic                hit
`endif
);

  localparam int CW = $clog2(SPRITE_W + 1);
  localparam int RW = $clog2(SPRITE_H + 1);
  localparam logic [X_W:0] XMAX   = (X_W + 1)'(SCREEN_W - SPRITE_W);
  localparam logic [Y_W:0] YMAX   = (Y_W + 1)'(SCREEN_H - SPRITE_H);
  localparam logic [X_W:0] STEP_X = (X_W + 1)'(STEP);
  localparam logic [Y_W:0] STEP_Y = (Y_W + 1)'(STEP);

  state_t state_q, state_d;
  logic [X_W-1:0]      pos_x_q, pos_x_d, base_x_q, base_x_d, x_hold_q, x_hold_d;
  logic [Y_W-1:0]      pos_y_q, pos_y_d, base_y_q, base_y_d, y_hold_q, y_hold_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                flying_q, flying_d;

  logic          accept, sweep_start, last_pix;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [X_W-1:0] pix_x;
  logic [Y_W-1:0] pix_y;
  logic [X_W:0]   x_ext, x_inc, x_dec;
  logic [Y_W:0]   y_ext, y_inc, y_dec;

  assign accept      = cmd_valid && cmd_ready;
  assign sweep_start = accept && (cmd == CMD_DRAW || cmd == CMD_CLEAR);

  sprite_raster_counter #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H)
  ) u_raster (
    .clk     (clk),
    .reset   (reset),
    .start   (sweep_start),
    .advance (plot),
    .col     (col),
    .row     (row),
    .last    (last_pix)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (sweep_start) state_d = ST_SWEEP;
      ST_SWEEP: if (last_pix)    state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    plot      = (state_q == ST_SWEEP);
    done      = (state_q == ST_SWEEP) && last_pix;
  end

  // Saturating steps are formed one bit wider than the position so nothing wraps.
  always_comb begin
    x_ext = {1'b0, pos_x_q};
    y_ext = {1'b0, pos_y_q};
    x_inc = (x_ext + STEP_X > XMAX) ? XMAX : x_ext + STEP_X;
    y_inc = (y_ext + STEP_Y > YMAX) ? YMAX : y_ext + STEP_Y;
    x_dec = (x_ext < STEP_X) ? '0 : x_ext - STEP_X;
    y_dec = (y_ext < STEP_Y) ? '0 : y_ext - STEP_Y;
  end

  always_comb begin
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    flying_d = flying_q;
    colour_d = colour_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    if (accept) begin
      case (cmd)
        CMD_HOME: begin
          pos_x_d  = X_W'(START_X);
          pos_y_d  = Y_W'(START_Y);
          flying_d = 1'b0;
        end
        CMD_MOVE: begin
          pos_x_d = dir[DIR_RIGHT_BIT] ? x_inc[X_W-1:0] : x_dec[X_W-1:0];
          pos_y_d = dir[DIR_DOWN_BIT]  ? y_inc[Y_W-1:0] : y_dec[Y_W-1:0];
        end
        CMD_FALL: begin
          flying_d = (y_ext < YMAX);
          if (y_ext < YMAX) pos_y_d = y_inc[Y_W-1:0];
        end
        CMD_ESCAPE: begin
          flying_d = (pos_y_q != '0);
          if (pos_y_q != '0) pos_y_d = y_dec[Y_W-1:0];
        end
        CMD_DRAW, CMD_CLEAR: begin
          colour_d = (cmd == CMD_DRAW) ? draw_colour : '0;
          base_x_d = pos_x_q;
          base_y_d = pos_y_q;
        end
        default: ;
      endcase
    end
  end

  // Between sweeps the pixel outputs replay the last plotted coordinate.
  always_comb begin
    pix_x    = base_x_q + X_W'(col);
    pix_y    = base_y_q + Y_W'(row);
    x_hold_d = plot ? pix_x : x_hold_q;
    y_hold_d = plot ? pix_y : y_hold_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_x_q  <= X_W'(START_X);
      pos_y_q  <= Y_W'(START_Y);
      flying_q <= 1'b0;
      colour_q <= '0;
      base_x_q <= '0;
      base_y_q <= '0;
      x_hold_q <= '0;
      y_hold_q <= '0;
    end else begin
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      flying_q <= flying_d;
      colour_q <= colour_d;
      base_x_q <= base_x_d;
      base_y_q <= base_y_d;
      x_hold_q <= x_hold_d;
      y_hold_q <= y_hold_d;
    end
  end

  assign x_out  = plot ? pix_x : x_hold_q;
  assign y_out  = plot ? pix_y : y_hold_q;
  assign colour = colour_q;
  assign flying = flying_q;
  assign pos_x  = pos_x_q;
  assign pos_y  = pos_y_q;

`ifdef SPRITE_MOVER_HIT_EN
  logic hit_q, hit_d;
  logic [X_W:0] aim_x_ext;
  logic [Y_W:0] aim_y_ext;

  // Box test uses the pre-edge position, so a same-cycle MOVE does not affect it.
  always_comb begin
    aim_x_ext = {1'b0, aim_x};
    aim_y_ext = {1'b0, aim_y};
    hit_d = fire && !flying_q
         && (aim_x_ext >= x_ext) && (aim_x_ext <= x_ext + (X_W + 1)'(SPRITE_W - 1))
         && (aim_y_ext >= y_ext) && (aim_y_ext <= y_ext + (Y_W + 1)'(SPRITE_H - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hit_q <= 1'b0;
    else       hit_q <= hit_d;
  end

  assign hit = hit_q;
`endif

endmodule
